// File: rtl/lc3_io_pkg.sv
// Shared LC-3 I/O definitions: display FSM states and DSR layout.
// Used by the display output controller and its FIFO neighbours.
package lc3_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_LOAD,
    ST_GAP
  } disp_st_e;

  localparam int DSR_RDY  = 15;
  localparam int DSR_OVR  = 14;
  localparam int DSR_BUSY = 13;

  localparam logic [15:0] DSR_RST = 16'h8000;

  function automatic logic [15:0] dsr_pack(
    input logic rdy,
    input logic ovr,
    input logic busy
  );
    logic [15:0] v;
    v = '0;
    v[DSR_RDY]  = rdy;
    v[DSR_OVR]  = ovr;
    v[DSR_BUSY] = busy;
    return v;
  endfunction

endpackage

// File: rtl/lc3_display_out_ctrl_if.sv
// Display transmitter handshake bundle.
// Signal prefixes are from the controller's point of view.
interface lc3_display_out_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_ld;

  modport master (
    output o_tx_data,
    output o_tx_valid,
    output o_ld,
    input  i_tx_ready
  );

  modport slave (
    input  o_tx_data,
    input  o_tx_valid,
    input  o_ld,
    output i_tx_ready
  );
endinterface

// File: rtl/lc3_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Push while full and pop while empty are ignored.
module lc3_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CW-1:0]     o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/lc3_display_out_ctrl.sv
// LC-3 display output controller: DDR write FIFO, paced
// transmitter handshake and registered display status register.
module lc3_display_out_ctrl
  import lc3_io_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int DEPTH      = 4,
  parameter  int GAP_CYCLES = 0,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_ddr_wr,
  input  logic [DATA_W-1:0] i_ddr_data,
  input  logic              i_ovr_clr,
  output logic [15:0]       o_dsr,
  lc3_display_out_ctrl_if.master tx,
  output logic [CW-1:0]     o_count
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LD =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  disp_st_e          r_state;
  disp_st_e          w_state_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_tx_valid;
  logic              w_valid_nxt;
  logic              r_ld;
  logic              w_ld_nxt;
  logic [GW-1:0]     r_gap;
  logic [GW-1:0]     w_gap_nxt;
  logic              r_ovr;
  logic              w_ovr_nxt;
  logic [15:0]       r_dsr;
  logic [15:0]       w_dsr_nxt;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_cnt_nxt;

  lc3_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_push  (w_push),
    .i_data  (i_ddr_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_push = i_ddr_wr & ~w_full;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_data_nxt  = r_tx_data;
    w_valid_nxt = r_tx_valid;
    w_ld_nxt    = 1'b0;
    w_gap_nxt   = r_gap;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_data_nxt  = w_head;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (tx.i_tx_ready) begin
          w_valid_nxt = 1'b0;
          w_ld_nxt    = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (GAP_CYCLES > 0) begin
          w_gap_nxt   = GAP_LD;
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gap == '0) w_state_nxt = ST_IDLE;
        else             w_gap_nxt   = r_gap - GW'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Overrun set beats clear; DSR is built from post-edge values.
  always_comb begin
    w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);
    w_ovr_nxt = (i_ddr_wr & w_full) | (r_ovr & ~i_ovr_clr);
    w_dsr_nxt = dsr_pack(
      w_cnt_nxt != CW'(DEPTH),
      w_ovr_nxt,
      (w_state_nxt != ST_IDLE) || (w_cnt_nxt != '0)
    );
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_ld       <= 1'b0;
      r_gap      <= '0;
      r_ovr      <= 1'b0;
      r_dsr      <= DSR_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_data  <= w_data_nxt;
      r_tx_valid <= w_valid_nxt;
      r_ld       <= w_ld_nxt;
      r_gap      <= w_gap_nxt;
      r_ovr      <= w_ovr_nxt;
      r_dsr      <= w_dsr_nxt;
    end
  end

  assign tx.o_tx_data  = r_tx_data;
  assign tx.o_tx_valid = r_tx_valid;
  assign tx.o_ld       = r_ld;
  assign o_dsr         = r_dsr;
  assign o_count       = w_count;

endmodule

// File: tb/tb_lc3_display_out_ctrl.sv
// Bench for lc3_display_out_ctrl: queue-based reference model
// for the unpaced instance plus a paced (GAP_CYCLES=3) instance.
module tb_lc3_display_out_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr, clr;
  logic [DW-1:0] d;
  logic [15:0]   dsr;
  logic [CW-1:0] cnt;
  logic          g_wr, g_clr;
  logic [DW-1:0] g_d;
  logic [15:0]   g_dsr;
  logic [CW-1:0] g_cnt;

  int total = 0;
  int bad   = 0;

  lc3_display_out_ctrl_if #(.DATA_W(DW)) if0 ();
  lc3_display_out_ctrl_if #(.DATA_W(DW)) if1 ();

  lc3_display_out_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(0)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_ddr_wr(wr), .i_ddr_data(d), .i_ovr_clr(clr),
    .o_dsr(dsr), .tx(if0.master), .o_count(cnt)
  );

  lc3_display_out_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(3)
  ) dut_gap (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_ddr_wr(g_wr), .i_ddr_data(g_d), .i_ovr_clr(g_clr),
    .o_dsr(g_dsr), .tx(if1.master), .o_count(g_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: pending queue, character in hand, and
  // cycles left before the sender may take the next character.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_cur;
  bit            m_present;
  bit            m_ld;
  bit            m_ovr;
  int            m_wait;

  function automatic void m_reset();
    mq.delete();
    m_cur = '0; m_present = 0; m_ld = 0;
    m_ovr = 0; m_wait = 0;
  endfunction

  function automatic bit m_pop_next();
    return !m_present && m_wait == 0 && mq.size() > 0;
  endfunction

  function automatic logic [15:0] m_dsr();
    logic [15:0] v;
    v = '0;
    v[15] = (mq.size() != DEPTH);
    v[14] = m_ovr;
    v[13] = m_present || m_wait > 0 || mq.size() > 0;
    return v;
  endfunction

  task automatic tick(input logic w, input logic [DW-1:0] dd,
                      input logic r, input logic c);
    bit full, pop;
    wr = w; d = dd; if0.i_tx_ready = r; clr = c;
    full = (mq.size() == DEPTH);
    pop  = m_pop_next();
    @(posedge clk);
    m_ld = 0;
    if (m_present && r) begin
      m_present = 0; m_ld = 1; m_wait = 1;
    end else if (!m_present && m_wait > 0) begin
      m_wait--;
    end
    if (w && full) m_ovr = 1;
    else if (c)    m_ovr = 0;
    if (pop) begin
      m_cur = mq.pop_front(); m_present = 1;
    end
    if (w && !full) mq.push_back(dd);
    #1;
    wr = 0; clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; wr = 0; clr = 0; d = '0;
    if0.i_tx_ready = 0;
    g_wr = 0; g_clr = 0; g_d = '0; if1.i_tx_ready = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dsr !== 16'h8000) begin
      bad++; $display("FAIL rst_dsr got=%h exp=8000", dsr);
    end
    total++;
    if (if0.o_tx_valid !== 1'b0 || if0.o_ld !== 1'b0) begin
      bad++; $display("FAIL rst_vld_ld got=%b%b exp=00",
                      if0.o_tx_valid, if0.o_ld);
    end
    total++;
    if (cnt !== '0 || if0.o_tx_data !== '0) begin
      bad++; $display("FAIL rst_cnt_data got=%0d/%h exp=0/00",
                      cnt, if0.o_tx_data);
    end
    @(negedge clk);
    rst_n = 1;
    tick(0, 0, 0, 0);
  endtask

  task automatic test_single();
    tick(1, 8'h41, 1, 0);
    total++;
    if (if0.o_tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_v0 got=%b exp=0", if0.o_tx_valid);
    end
    tick(0, 0, 1, 0);
    total++;
    if (if0.o_tx_valid !== 1'b1 || if0.o_tx_data !== 8'h41) begin
      bad++; $display("FAIL single_v1 got=%b/%h exp=1/41",
                      if0.o_tx_valid, if0.o_tx_data);
    end
    tick(0, 0, 1, 0);
    total++;
    if (if0.o_ld !== 1'b1 || if0.o_tx_valid !== 1'b0) begin
      bad++; $display("FAIL single_ld got=%b/%b exp=1/0",
                      if0.o_ld, if0.o_tx_valid);
    end
    tick(0, 0, 1, 0);
    total++;
    if (if0.o_ld !== 1'b0 || dsr !== 16'h8000) begin
      bad++; $display("FAIL single_end got=%b/%h exp=0/8000",
                      if0.o_ld, dsr);
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] got[$];
    for (int i = 0; i < 5; i++) tick(1, 8'h41 + DW'(i), 0, 0);
    total++;
    if (cnt !== CW'(4) || dsr[15] !== 1'b0) begin
      bad++; $display("FAIL ovr_full got=%0d/%b exp=4/0", cnt, dsr[15]);
    end
    total++;
    if (if0.o_tx_data !== 8'h41 || dsr[14] !== 1'b0) begin
      bad++; $display("FAIL ovr_head got=%h/%b exp=41/0",
                      if0.o_tx_data, dsr[14]);
    end
    tick(1, 8'h46, 0, 0);
    total++;
    if (dsr[14] !== 1'b1 || cnt !== CW'(4)) begin
      bad++; $display("FAIL ovr_set got=%b/%0d exp=1/4", dsr[14], cnt);
    end
    tick(0, 0, 0, 1);
    total++;
    if (dsr[14] !== 1'b0) begin
      bad++; $display("FAIL ovr_clr got=%b exp=0", dsr[14]);
    end
    for (int i = 0; i < 40; i++) begin
      if (!m_present && m_wait == 0 && mq.size() == 0) break;
      tick(0, 0, 1, 0);
      if (if0.o_ld) got.push_back(if0.o_tx_data);
    end
    total++;
    if (got.size() != 5) begin
      bad++; $display("FAIL ovr_drain_n got=%0d exp=5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (got[i] !== 8'h41 + DW'(i)) begin
          bad++; $display("FAIL ovr_order[%0d] got=%h exp=%h",
                          i, got[i], 8'h41 + DW'(i));
        end
      end
    end
  endtask

  task automatic test_stall();
    int lds;
    tick(1, 8'h5A, 0, 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      total++;
      if (if0.o_tx_valid !== 1'b1 || if0.o_tx_data !== 8'h5A ||
          if0.o_ld !== 1'b0) begin
        bad++; $display("FAIL stall[%0d] got=%b/%h/%b exp=1/5a/0",
                        i, if0.o_tx_valid, if0.o_tx_data, if0.o_ld);
      end
    end
    lds = 0;
    tick(0, 0, 1, 0);
    if (if0.o_ld) lds++;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0);
      if (if0.o_ld) lds++;
    end
    total++;
    if (lds != 1) begin
      bad++; $display("FAIL stall_ld got=%0d exp=1", lds);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] chars[10];
    logic [DW-1:0] got[$];
    int  nxt;
    bit  w, seen;
    foreach (chars[i]) chars[i] = DW'($urandom);
    nxt = 0; seen = 0;
    for (int i = 0; i < 200 && got.size() < 10; i++) begin
      bit both;
      w = (nxt < 10) &&
          (mq.size() < 2 || (mq.size() == 2 && m_pop_next()));
      both = w && m_pop_next() && mq.size() == 2;
      tick(w, w ? chars[nxt] : '0, 1, 0);
      if (w) nxt++;
      if (both) begin
        seen = 1;
        total++;
        if (cnt !== CW'(2)) begin
          bad++; $display("FAIL pushpop_cnt got=%0d exp=2", cnt);
        end
      end
      if (if0.o_ld) got.push_back(if0.o_tx_data);
    end
    total++;
    if (!seen || got.size() != 10) begin
      bad++; $display("FAIL b2b_run got=%0d/%b exp=10/1",
                      got.size(), seen);
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (got[i] !== chars[i]) begin
          bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h",
                          i, got[i], chars[i]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int rise[$];
    int lds;
    bit pv;
    lds = 0; pv = 0;
    if1.i_tx_ready = 1;
    for (int c = 0; c < 40; c++) begin
      g_wr = (c < 2);
      g_d  = 8'h61 + DW'(c);
      @(posedge clk);
      #1;
      g_wr = 0;
      if (if1.o_tx_valid && !pv) rise.push_back(c);
      pv = if1.o_tx_valid;
      if (lds < 2) begin
        total++;
        if (g_dsr[13] !== 1'b1) begin
          bad++; $display("FAIL gap_busy c=%0d got=%b exp=1", c, g_dsr[13]);
        end
      end
      if (if1.o_ld) lds++;
    end
    total++;
    if (rise.size() != 2 || lds != 2) begin
      bad++; $display("FAIL gap_count got=%0d/%0d exp=2/2",
                      rise.size(), lds);
    end else begin
      total++;
      if (rise[1] - rise[0] != 6) begin
        bad++; $display("FAIL gap_space got=%0d exp=6",
                        rise[1] - rise[0]);
      end
    end
    total++;
    if (g_dsr !== 16'h8000) begin
      bad++; $display("FAIL gap_idle got=%h exp=8000", g_dsr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 2) == 0, DW'($urandom),
           ($urandom % 3) != 0, ($urandom % 10) == 0);
      total++;
      if (if0.o_tx_valid !== m_present || if0.o_ld !== m_ld) begin
        bad++; $display("FAIL rnd_hs[%0d] got=%b%b exp=%b%b", i,
                        if0.o_tx_valid, if0.o_ld, m_present, m_ld);
      end
      total++;
      if (cnt !== CW'(mq.size()) || dsr !== m_dsr()) begin
        bad++; $display("FAIL rnd_st[%0d] got=%0d/%h exp=%0d/%h", i,
                        cnt, dsr, mq.size(), m_dsr());
      end
      if (m_present) begin
        total++;
        if (if0.o_tx_data !== m_cur) begin
          bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i,
                          if0.o_tx_data, m_cur);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12; i++) tick(0, 0, 1, 1);
    tick(1, 8'h33, 0, 0);
    tick(1, 8'h34, 0, 0);
    total++;
    if (if0.o_tx_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got=%b exp=1", if0.o_tx_valid);
    end
    rst_n = 0;
    #1;
    total++;
    if (if0.o_tx_valid !== 1'b0 || if0.o_ld !== 1'b0 ||
        dsr !== 16'h8000 || cnt !== '0) begin
      bad++; $display("FAIL mid_rst got=%b/%b/%h/%0d exp=0/0/8000/0",
                      if0.o_tx_valid, if0.o_ld, dsr, cnt);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
    total++;
    if (if0.o_tx_valid !== 1'b0 || if0.o_ld !== 1'b0) begin
      bad++; $display("FAIL mid_lost got=%b%b exp=00",
                      if0.o_tx_valid, if0.o_ld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_stall();
    test_back_to_back();
    test_gap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
